// File: rtl/sram_arbiter_if.sv
// Bundle of the three requester ports and the ram_ctrl port shared by sram_arbiter.
// The arbiter takes the slave side; requesters and ram_ctrl sit on the master side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    // Handshake: each *_req is a level held with stable addr/data/we until the
    // matching one-cycle *_ack; the requester drops req the cycle after ack.
    // ram_read/ram_write are levels held until ram_done, and ram_done stays
    // high until the arbiter has dropped both strobes.
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_q;
    logic              vga_ack;

    logic              cam_req;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_ack;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_done;

    logic [1:0]        grant_id;
    logic              tmo_err;

    modport slave (
        input  vga_req, vga_addr,
        input  cam_req, cam_addr, cam_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_rdata, ram_done,
        output vga_q, vga_ack,
        output cam_ack,
        output host_rdata, host_ack,
        output ram_read, ram_write, ram_addr, ram_wdata,
        output grant_id, tmo_err
    );

    modport master (
        output vga_req, vga_addr,
        output cam_req, cam_addr, cam_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output ram_rdata, ram_done,
        input  vga_q, vga_ack,
        input  cam_ack,
        input  host_rdata, host_ack,
        input  ram_read, ram_write, ram_addr, ram_wdata,
        input  grant_id, tmo_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one ram_ctrl port between VGA (read, strict priority), camera (write)
// and host (read/write); camera and host alternate round-robin.
module sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int TMO    = 255
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_VGA  = 2'd1;
    localparam logic [1:0] ID_CAM  = 2'd2;
    localparam logic [1:0] ID_HOST = 2'd3;

    // Timeout fires on the WAIT cycle whose count equals TMO-1, i.e. after TMO cycles.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t            state;
    state_t            state_nxt;

    logic              rr_host;
    logic [1:0]        owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [7:0]        wait_cnt;
    logic [1:0]        grant_r;
    logic              vga_ack_r;
    logic              cam_ack_r;
    logic              host_ack_r;
    logic              tmo_r;
    logic [DATA_W-1:0] vga_q_r;
    logic [DATA_W-1:0] host_rdata_r;

    logic              any_req;
    logic              sel_vga;
    logic              sel_cam;
    logic              sel_host;
    logic [1:0]        win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              wait_done;
    logic              wait_tmo;
    logic              wait_exit;
    logic [DATA_W-1:0] rd_value;
    logic              ram_read_c;
    logic              ram_write_c;

    // Winner selection: VGA first; camera/host by pointer only when both pend.
    always_comb begin
        sel_vga  = bus.vga_req;
        sel_cam  = !bus.vga_req && bus.cam_req  && (!bus.host_req || !rr_host);
        sel_host = !bus.vga_req && bus.host_req && (!bus.cam_req  ||  rr_host);
        any_req  = bus.vga_req || bus.cam_req || bus.host_req;
        win_id    = ID_NONE;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (sel_vga) begin
            win_id   = ID_VGA;
            win_addr = bus.vga_addr;
        end else if (sel_cam) begin
            win_id    = ID_CAM;
            win_we    = 1'b1;
            win_addr  = bus.cam_addr;
            win_wdata = bus.cam_wdata;
        end else if (sel_host) begin
            win_id    = ID_HOST;
            win_we    = bus.host_we;
            win_addr  = bus.host_addr;
            win_wdata = bus.host_wdata;
        end
    end

    always_comb begin
        wait_done = (state == S_WAIT) && bus.ram_done;
        wait_tmo  = (state == S_WAIT) && !bus.ram_done && (wait_cnt == TMO_LAST);
        wait_exit = wait_done || wait_tmo;
        rd_value  = wait_done ? bus.ram_rdata : '0;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (any_req) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (wait_exit) state_nxt = S_RELEASE;
            S_RELEASE: if (!bus.ram_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. Strobes are decoded from registered state, so they rise on
    // the edge that leaves ISSUE and fall on the edge that leaves WAIT.
    always_comb begin
        ram_read_c  = (state == S_WAIT) && !lat_we;
        ram_write_c = (state == S_WAIT) &&  lat_we;
        state_dbg   = state;
    end

    // Transaction latch, wait counter, acks and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_host      <= 1'b0;
            owner        <= ID_NONE;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_we       <= 1'b0;
            wait_cnt     <= '0;
            grant_r      <= ID_NONE;
            vga_ack_r    <= 1'b0;
            cam_ack_r    <= 1'b0;
            host_ack_r   <= 1'b0;
            tmo_r        <= 1'b0;
            vga_q_r      <= '0;
            host_rdata_r <= '0;
        end else begin
            vga_ack_r  <= 1'b0;
            cam_ack_r  <= 1'b0;
            host_ack_r <= 1'b0;
            tmo_r      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= win_id;
                        grant_r   <= win_id;
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        lat_we    <= win_we;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_exit) begin
                        tmo_r      <= wait_tmo;
                        vga_ack_r  <= (owner == ID_VGA);
                        cam_ack_r  <= (owner == ID_CAM);
                        host_ack_r <= (owner == ID_HOST);
                        if (!lat_we && owner == ID_VGA) vga_q_r <= rd_value;
                        if (!lat_we && owner == ID_HOST) host_rdata_r <= rd_value;
                    end
                end
                S_RELEASE: begin
                    if (!bus.ram_done) begin
                        grant_r <= ID_NONE;
                        if (owner == ID_CAM)  rr_host <= 1'b1;
                        if (owner == ID_HOST) rr_host <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_read   = ram_read_c;
    assign bus.ram_write  = ram_write_c;
    assign bus.ram_addr   = lat_addr;
    assign bus.ram_wdata  = lat_wdata;
    assign bus.vga_q      = vga_q_r;
    assign bus.vga_ack    = vga_ack_r;
    assign bus.cam_ack    = cam_ack_r;
    assign bus.host_rdata = host_rdata_r;
    assign bus.host_ack   = host_ack_r;
    assign bus.grant_id   = grant_r;
    assign bus.tmo_err    = tmo_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model with variable latency, transaction-level
// arbitration/memory model, directed scenarios and randomized traffic.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_errors = 0;
    logic [54:0]       exp_q[$];        // {id[1:0], we, addr[19:0], wdata[31:0]}
    int                ack_log[$];
    logic [DW-1:0]     ref_mem [logic [AW-1:0]];
    logic [DW-1:0]     sram_mem [logic [AW-1:0]];
    bit                cam_first = 1'b1;
    int                busy_cycles = 0;
    int                last_busy = 0;
    bit                done_seen = 1'b0;
    int                write_cycles = 0;
    int                last_grant = 0;
    bit                stall = 1'b0;
    int                lat_cfg = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- SRAM model (ram_ctrl stand-in) ----------------
    initial begin : sram_model
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        bus.ram_done  = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                cnt = 0;
                bus.ram_done = 1'b0;
            end else if (bus.ram_read || bus.ram_write) begin
                if (!bus.ram_done && !stall) begin
                    if (cnt == 0) lat = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 4);
                    cnt++;
                    if (cnt >= lat) begin
                        if (bus.ram_write) sram_mem[bus.ram_addr] = bus.ram_wdata;
                        else bus.ram_rdata = sram_mem.exists(bus.ram_addr) ? sram_mem[bus.ram_addr] : '0;
                        bus.ram_done = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
                bus.ram_done = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin : compare
        logic          sv, sc, sh, shw;
        logic [AW-1:0] sva, sca, sha;
        logic [DW-1:0] scd, shd;
        logic [1:0]    prev_grant;
        logic [54:0]   t;
        logic [DW-1:0] exp_rd, got_rd;
        int            w, id, nack, gap;
        bit            issue_wait, pending_done, busy;
        prev_grant = 2'd0;
        issue_wait = 1'b0;
        pending_done = 1'b0;
        gap = 0;
        forever begin
            @(posedge clk);
            sv = bus.vga_req;  sva = bus.vga_addr;
            sc = bus.cam_req;  sca = bus.cam_addr;  scd = bus.cam_wdata;
            sh = bus.host_req; sha = bus.host_addr; shd = bus.host_wdata; shw = bus.host_we;
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                cam_first = 1'b1;
                prev_grant = 2'd0;
                busy_cycles = 0;
                done_seen = 1'b0;
                issue_wait = 1'b0;
                pending_done = 1'b0;
                continue;
            end
            busy = bus.ram_read || bus.ram_write;
            nack = int'(bus.vga_ack) + int'(bus.cam_ack) + int'(bus.host_ack);
            check("rw_exclusive", {bus.ram_read, bus.ram_write} == 2'b11, 1'b0);
            check("ack_onehot", nack <= 1, 1'b1);
            if (pending_done) check("ack_latency", nack, 1);
            pending_done = busy && bus.ram_done;
            if (issue_wait) begin
                gap++;
                if (busy) begin
                    check("issue_latency", gap, 1);
                    issue_wait = 1'b0;
                end
            end
            if (prev_grant == 2'd0 && bus.grant_id != 2'd0) begin
                if (sv) w = 1;
                else if (sc && (!sh || cam_first)) w = 2;
                else if (sh) w = 3;
                else w = 0;
                check("grant_winner", bus.grant_id, w);
                if (w == 2) cam_first = 1'b0;
                if (w == 3) cam_first = 1'b1;
                case (w)
                    1: t = {2'd1, 1'b0, sva, 32'd0};
                    2: t = {2'd2, 1'b1, sca, scd};
                    default: t = {2'd3, shw, sha, shd};
                endcase
                exp_q.push_back(t);
                last_grant = w;
                busy_cycles = 0;
                done_seen = 1'b0;
                issue_wait = 1'b1;
                gap = 0;
            end
            if (busy) begin
                busy_cycles++;
                if (bus.ram_write) write_cycles++;
                if (bus.ram_done) done_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("ram_unexpected", 1'b1, 1'b0);
                end else begin
                    check("ram_addr", bus.ram_addr, exp_q[0][51:32]);
                    check("ram_dir", bus.ram_write, exp_q[0][52]);
                    if (exp_q[0][52]) check("ram_wdata", bus.ram_wdata, exp_q[0][31:0]);
                end
            end
            if (bus.tmo_err && nack == 0) check("tmo_without_ack", 1'b1, 1'b0);
            if (nack != 0) begin
                id = bus.vga_ack ? 1 : (bus.cam_ack ? 2 : 3);
                ack_log.push_back(id);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 1'b1, 1'b0);
                end else begin
                    t = exp_q.pop_front();
                    last_busy = busy_cycles;
                    check("ack_id", id, t[54:53]);
                    check("tmo_err", bus.tmo_err, !done_seen);
                    if (!done_seen) check("tmo_length", busy_cycles, 255);
                    if (t[52]) begin
                        if (!bus.tmo_err) ref_mem[t[51:32]] = t[31:0];
                    end else begin
                        exp_rd = bus.tmo_err ? '0 : (ref_mem.exists(t[51:32]) ? ref_mem[t[51:32]] : '0);
                        got_rd = (id == 1) ? bus.vga_q : bus.host_rdata;
                        check("read_data", got_rd, exp_rd);
                    end
                end
            end
            prev_grant = bus.grant_id;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input int who, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic tmo);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        rd = '0;
        tmo = 1'b0;
        case (who)
            1: begin bus.vga_addr = a; bus.vga_req = 1'b1; end
            2: begin bus.cam_addr = a; bus.cam_wdata = d; bus.cam_req = 1'b1; end
            default: begin
                bus.host_addr = a; bus.host_wdata = d; bus.host_we = we; bus.host_req = 1'b1;
            end
        endcase
        while (!got && n < 2000) begin
            @(negedge clk);
            n++;
            if (who == 1 && bus.vga_ack)  begin got = 1'b1; rd = bus.vga_q;      tmo = bus.tmo_err; end
            if (who == 2 && bus.cam_ack)  begin got = 1'b1;                       tmo = bus.tmo_err; end
            if (who == 3 && bus.host_ack) begin got = 1'b1; rd = bus.host_rdata; tmo = bus.tmo_err; end
        end
        check($sformatf("ack_wait_%0d", who), got, 1'b1);
        @(posedge clk);
        #1;
        case (who)
            1: bus.vga_req = 1'b0;
            2: bus.cam_req = 1'b0;
            default: bus.host_req = 1'b0;
        endcase
    endtask

    task automatic rand_driver(input int who, input int n);
        logic [DW-1:0] rd;
        logic          tmo;
        logic          we;
        int            gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            we = (who == 2) ? 1'b1 : ((who == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
            do_req(who, we, AW'($urandom_range(0, 15)), $urandom, rd, tmo);
        end
    endtask

    function automatic int count_id(input int id);
        int c;
        c = 0;
        foreach (ack_log[i]) if (ack_log[i] == id) c++;
        return c;
    endfunction

    function automatic int log_at(input int i);
        return (i < ack_log.size()) ? ack_log[i] : -1;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        logic [DW-1:0] rd, rd1, rd2, rd3, rd5;
        logic          tmo, tm1, tm2, tm3, tmo5;
        int            wc0, n;
        bit            seen;
        int            exp_alt[6];

        bus.vga_req = 1'b0;  bus.vga_addr = '0;
        bus.cam_req = 1'b0;  bus.cam_addr = '0;  bus.cam_wdata = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_read", bus.ram_read, 1'b0);
        check("rst_ram_write", bus.ram_write, 1'b0);
        check("rst_grant", bus.grant_id, 2'd0);
        check("rst_acks", {bus.vga_ack, bus.cam_ack, bus.host_ack}, 3'b000);
        check("rst_tmo", bus.tmo_err, 1'b0);
        check("rst_vga_q", bus.vga_q, 32'd0);
        check("rst_host_rdata", bus.host_rdata, 32'd0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single host write, memory answers after 3 cycles.
        lat_cfg = 3;
        ack_log.delete();
        wc0 = write_cycles;
        do_req(3, 1'b1, 20'h00010, 32'hA5A5_0001, rd, tmo);
        check("t1_write_cycles", write_cycles - wc0, 3);
        check("t1_ack_count", ack_log.size(), 1);
        check("t1_ack_who", log_at(0), 3);
        check("t1_grant_seen", last_grant, 3);
        check("t1_tmo", tmo, 1'b0);
        @(negedge clk);
        check("t1_grant_back", bus.grant_id, 2'd0);
        @(posedge clk);
        #1;

        // Host read-back of the same word.
        wc0 = write_cycles;
        do_req(3, 1'b0, 20'h00010, 32'h0, rd, tmo);
        check("t2_rdata", rd, 32'hA5A5_0001);
        check("t2_no_write", write_cycles - wc0, 0);
        lat_cfg = 0;

        // Simultaneous requests, then continuous cam+host contention.
        ack_log.delete();
        fork
            do_req(1, 1'b0, 20'h00010, 32'h0, rd1, tm1);
            do_req(2, 1'b1, 20'h00011, 32'hC0DE_0002, rd2, tm2);
            do_req(3, 1'b0, 20'h00010, 32'h0, rd3, tm3);
        join
        check("t3_order0", log_at(0), 1);
        check("t3_order1", log_at(1), 2);
        check("t3_order2", log_at(2), 3);
        check("t3_vga_data", rd1, 32'hA5A5_0001);
        ack_log.delete();
        fork
            begin repeat (3) do_req(2, 1'b1, 20'h00012, 32'h0000_CA11, rd2, tm2); end
            begin repeat (3) do_req(3, 1'b1, 20'h00013, 32'h0000_4057, rd3, tm3); end
        join
        exp_alt = '{2, 3, 2, 3, 2, 3};
        for (int i = 0; i < 6; i++) check($sformatf("t3_alt%0d", i), log_at(i), exp_alt[i]);

        // ram_done stuck low: timeout abort, then normal service.
        stall = 1'b1;
        ack_log.delete();
        do_req(1, 1'b0, 20'h00011, 32'h0, rd, tmo);
        check("t4_tmo", tmo, 1'b1);
        check("t4_rdata_zero", rd, 32'd0);
        check("t4_wait_cycles", last_busy, 255);
        check("t4_ack_count", ack_log.size(), 1);
        stall = 1'b0;
        do_req(1, 1'b0, 20'h00011, 32'h0, rd, tmo);
        check("t4_after_tmo", tmo, 1'b0);
        check("t4_after_data", rd, 32'hC0DE_0002);

        // Reset while a camera write waits.
        stall = 1'b1;
        ack_log.delete();
        fork
            do_req(2, 1'b1, 20'h00020, 32'h1234_5678, rd5, tmo5);
        join_none
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = bus.ram_write;
        end
        check("t5_write_started", seen, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_write", bus.ram_write, 1'b0);
        check("t5_rst_read", bus.ram_read, 1'b0);
        check("t5_rst_grant", bus.grant_id, 2'd0);
        check("t5_rst_state", state_dbg, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_no_ack", ack_log.size(), 0);
        check("t5_rst_tmo", bus.tmo_err, 1'b0);
        stall = 1'b0;
        #2 rst = 1'b1;
        wait fork;
        check("t5_cam_acks", count_id(2), 1);
        check("t5_cam_tmo", tmo5, 1'b0);
        do_req(1, 1'b0, 20'h00020, 32'h0, rd, tmo);
        check("t5_readback", rd, 32'h1234_5678);

        // Randomized mixed traffic.
        ack_log.delete();
        fork
            rand_driver(1, 1000);
            rand_driver(2, 1000);
            rand_driver(3, 1000);
        join
        repeat (4) @(negedge clk);
        check("rand_vga_acks", count_id(1), 1000);
        check("rand_cam_acks", count_id(2), 1000);
        check("rand_host_acks", count_id(3), 1000);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
